ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  Execute stage; consumes the ID/EX register bundle (DEC_out_t) and drives the registered EX/MEM bundle.
//  Forwards rs1/rs2 from MEM and WB, computes ALU results, and runs an iterative RV32M mul/div unit.
//  Holds stall high so the front end freezes while mul/div is busy.
// PARAMETERS
//  BITS_PER_CYCLE  1   quotient/multiplier bits retired per mul/div iteration; legal values 1, 2, 4
// PORTS
//  Clock        in   1    single clock; all state updates on posedge
//  nReset       in   1    synchronous, active-low reset
//  DEC_in       in   DEC_out_t  ID/EX bundle; aluin1_m/aluin2_m are not used by this block
//  rs1, rs2     in   32   register-file read data paired with DEC_in.addr1/addr2
//  md_op        in   1    instruction is RV32M; DEC_in.func3 selects MUL..REMU
//  mem_rd       in   5    MEM-stage destination register
//  mem_Wreg     in   1    MEM-stage write enable
//  mem_result   in   32   MEM-stage ALU result
//  wb_rd        in   5    WB-stage destination register
//  wb_Wreg      in   1    WB-stage write enable
//  wb_data      in   32   WB-stage write data
//  flush        in   1    kill the instruction in EX
//  EX_out       out  EX_out_t  registered bundle: PC, rd, result, store_data, Wmem, Rmem, Wreg, func3
//  stall        out  1    freezes IF, ID and the ID/EX register
// BEHAVIOUR
//  Reset (nReset=0 at posedge):
//   - every EX_out field is 0; md FSM goes to IDLE; stall=0 from the next cycle.
//  Forwarding (combinational), per operand:
//   - priority: MEM match (mem_Wreg & mem_rd==addr) > WB match > rs input.
//   - addr==0 never forwards.
//  Operand selection:
//   - A = aluPC_m ? fwd_rs1 : PC.
//   - B = aluImm_m ? imm : fwd_rs2.
//   - store_data = fwd_rs2.
//  ALU (alu_op_t on aluCode):
//   - ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9 PASSB10.
//   - Codes 11-15 give result 0. Shifts use B[4:0]. All arithmetic wraps at 32 bits.
//  Non-md instruction:
//   - EX_out loads at the next posedge (1-cycle latency); stall=0.
//  md FSM: IDLE -> BUSY -> DONE -> IDLE.
//   - IDLE & md_op & !flush: stall=1 combinationally in that cycle. Latch operands (fwd_rs1, fwd_rs2), func3, rd, PC.
//     Set count = 32/BITS_PER_CYCLE. Go to BUSY.
//   - BUSY: retire BITS_PER_CYCLE bits per cycle and decrement count; count==1 -> DONE. stall=1.
//   - DONE: stall=0. Sign-corrected result goes to EX_out with Wreg=1. Next state IDLE.
//   - stall is high for exactly 32/BITS_PER_CYCLE + 1 cycles.
//   - While stall=1, EX_out loads a bubble (all fields 0) so MEM/WB drain.
//  md arithmetic:
//   - Operands are converted to magnitude per func3 signedness.
//   - Multiply is shift-add into a 64-bit accumulator.
//   - Divide is restoring; sign is fixed in DONE.
//   - MUL returns the low 32 bits; MULH/MULHSU/MULHU return the high 32 bits.
//   - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the dividend.
//   - DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000; the matching REM gives 0.
//  flush:
//   - Has priority over everything except reset.
//   - EX_out loads a bubble; the FSM aborts to IDLE from any state.
//   - stall=0 in the cycle after the flush.
//   - md_op together with flush never starts the FSM.
//  Reset in BUSY/DONE: FSM goes to IDLE, no result is written, stall=0 the next cycle.
// STRUCTURE
//  core_types_pkg additions:
//   - EX_out_t struct (field widths above)
//   - alu_op_t enum (codes above)
//   - md_func_t enum (func3: MUL0..REMU7)
//   - md_state_t {IDLE, BUSY, DONE}
//  Sub-module md_unit holds the FSM, counter, accumulator and sign fix-up.
//   - Ports: start, func3, a, b, flush, busy, done, result.
//  ex_stage holds forwarding, the ALU, the stall mux and the EX/MEM register.
// TESTING
//  1. Forwarding priority: ADD with addr1=5, imm=3, aluImm_m=1, aluPC_m=1; mem_rd=5/0x10, wb_rd=5/0x20 -> result 0x13;
//     with mem_Wreg=0 -> 0x23.
//  2. No x0 forwarding: addr1=0, mem_rd=0, mem_Wreg=1, mem_result=0xDEAD, rs1=0 -> ADD result 0x3 (imm=3).
//  3. DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF. At BITS_PER_CYCLE=1, stall high exactly 33 cycles;
//     EX_out is a bubble during the stall.
//  4. Corner cases: DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0.
//  5. MULH 0x80000000*0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF; MUL 7*6 -> 42.
//  6. flush in BUSY cycle 10: stall=0 next cycle, no Wreg, following ADD correct. Repeat with nReset=0 mid-BUSY:
//     EX_out all zero.

Source files
------------

// File: rtl/core_types_pkg.sv
// Shared pipeline types for the execute stage: ID/EX and EX/MEM bundles,
// ALU and mul/div opcodes, and the operand forwarding helper.
package core_types_pkg;

  typedef struct packed {
    logic [31:0] PC;
    logic [4:0]  addr1;
    logic [4:0]  addr2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  aluCode;
    logic [2:0]  func3;
    logic        aluPC_m;
    logic        aluImm_m;
    logic        aluin1_m;
    logic        aluin2_m;
    logic        Wmem;
    logic        Rmem;
    logic        Wreg;
  } DEC_out_t;

  typedef struct packed {
    logic [31:0] PC;
    logic [4:0]  rd;
    logic [31:0] result;
    logic [31:0] store_data;
    logic        Wmem;
    logic        Rmem;
    logic        Wreg;
    logic [2:0]  func3;
  } EX_out_t;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_t;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_func_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  // MEM beats WB beats the register file; x0 is never forwarded.
  function automatic logic [31:0] fwd_sel(
    input logic [4:0]  addr,
    input logic [31:0] rf_val,
    input logic        m_we,
    input logic [4:0]  m_rd,
    input logic [31:0] m_val,
    input logic        w_we,
    input logic [4:0]  w_rd,
    input logic [31:0] w_val
  );
    if (addr == 5'd0)                  return rf_val;
    else if (m_we && (m_rd == addr))   return m_val;
    else if (w_we && (w_rd == addr))   return w_val;
    else                               return rf_val;
  endfunction

endpackage

// File: rtl/ex_stage_md_unit.sv
// Iterative RV32M unit: shift-add multiply and restoring divide on magnitudes,
// with the sign fixed up combinationally while in DONE.
//
// state | meaning
// IDLE  | waiting for start; start is accepted in the same cycle
// BUSY  | retiring BITS_PER_CYCLE bits per cycle until count reaches 1
// DONE  | result valid for one cycle, then back to IDLE
module md_unit
  import core_types_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        start,
  input  logic [2:0]  func3,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [5:0] STEPS = 6'(32 / BITS_PER_CYCLE);

  md_state_t   state, state_n;
  md_func_t    func_q;
  logic [63:0] acc_q, mc_q, acc_step, mc_step, prod;
  logic [31:0] b_q, b_step, a_orig_q, quo, rem;
  logic [64:0] sh;
  logic [32:0] rem_t;
  logic [5:0]  count_q;
  logic        neg_q, negr_q, divz_q;
  logic        a_signed, b_signed, sa, sb;
  logic [31:0] amag, bmag;

  always_ff @(posedge Clock) begin
    if (!nReset) state <= IDLE;
    else         state <= state_n;
  end

  // busy also covers the accepting IDLE cycle so the front end freezes at once
  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: if (start) begin
        busy    = 1'b1;
        state_n = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (count_q == 6'd1) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (flush) begin
      state_n = IDLE;
      busy    = 1'b0;
      done    = 1'b0;
    end
  end

  always_comb begin
    a_signed = (func3 == MD_MULH) || (func3 == MD_MULHSU) || (func3 == MD_DIV) || (func3 == MD_REM);
    b_signed = (func3 == MD_MULH) || (func3 == MD_DIV) || (func3 == MD_REM);
    sa       = a_signed & a[31];
    sb       = b_signed & b[31];
    amag     = sa ? (32'd0 - a) : a;
    bmag     = sb ? (32'd0 - b) : b;
  end

  always_comb begin
    acc_step = acc_q;
    mc_step  = mc_q;
    b_step   = b_q;
    sh       = '0;
    rem_t    = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (func_q[2]) begin
        sh    = {acc_step, 1'b0};
        rem_t = sh[64:32];
        if (rem_t >= {1'b0, b_q}) begin
          rem_t = rem_t - {1'b0, b_q};
          sh[0] = 1'b1;
        end
        acc_step = {rem_t[31:0], sh[31:0]};
      end else begin
        if (b_step[0]) acc_step = acc_step + mc_step;
        mc_step = mc_step << 1;
        b_step  = b_step >> 1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      func_q   <= MD_MUL;
      acc_q    <= '0;
      mc_q     <= '0;
      b_q      <= '0;
      a_orig_q <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      negr_q   <= 1'b0;
      divz_q   <= 1'b0;
    end else if (state == IDLE && start && !flush) begin
      func_q   <= md_func_t'(func3);
      acc_q    <= {32'd0, amag};
      mc_q     <= {32'd0, amag};
      b_q      <= bmag;
      a_orig_q <= a;
      count_q  <= STEPS;
      neg_q    <= sa ^ sb;
      negr_q   <= sa;
      divz_q   <= (b == 32'd0);
      if (!func3[2]) acc_q <= '0;
    end else if (state == BUSY && !flush) begin
      acc_q   <= acc_step;
      mc_q    <= mc_step;
      b_q     <= b_step;
      count_q <= count_q - 6'd1;
    end
  end

  always_comb begin
    prod = neg_q ? (64'd0 - acc_q) : acc_q;
    quo  = acc_q[31:0];
    rem  = acc_q[63:32];
    case (func_q)
      MD_MUL:                        result = prod[31:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  result = prod[63:32];
      MD_DIV, MD_DIVU:               result = divz_q ? 32'hFFFF_FFFF : (neg_q ? (32'd0 - quo) : quo);
      default:                       result = divz_q ? a_orig_q : (negr_q ? (32'd0 - rem) : rem);
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, mul/div stall control and the
// registered EX/MEM bundle.
module ex_stage
  import core_types_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        Clock,
  input  logic        nReset,
  input  DEC_out_t    DEC_in,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        md_op,
  input  logic [4:0]  mem_rd,
  input  logic        mem_Wreg,
  input  logic [31:0] mem_result,
  input  logic [4:0]  wb_rd,
  input  logic        wb_Wreg,
  input  logic [31:0] wb_data,
  input  logic        flush,
  output EX_out_t     EX_out,
  output logic        stall
);

  logic [31:0] fwd_rs1, fwd_rs2, op_a, op_b, alu_res, md_result;
  logic [31:0] md_pc_q;
  logic [4:0]  md_rd_q;
  logic [2:0]  md_f3_q;
  logic        md_start, md_busy, md_done, stall_q;
  logic        unused_mux_sel;
  EX_out_t     ex_n;

  assign unused_mux_sel = DEC_in.aluin1_m ^ DEC_in.aluin2_m;

  always_comb begin
    fwd_rs1 = fwd_sel(DEC_in.addr1, rs1, mem_Wreg, mem_rd, mem_result, wb_Wreg, wb_rd, wb_data);
    fwd_rs2 = fwd_sel(DEC_in.addr2, rs2, mem_Wreg, mem_rd, mem_result, wb_Wreg, wb_rd, wb_data);
    op_a    = DEC_in.aluPC_m  ? fwd_rs1    : DEC_in.PC;
    op_b    = DEC_in.aluImm_m ? DEC_in.imm : fwd_rs2;
  end

  always_comb begin
    alu_res = '0;
    case (alu_op_t'(DEC_in.aluCode))
      ALU_ADD:   alu_res = op_a + op_b;
      ALU_SUB:   alu_res = op_a - op_b;
      ALU_SLL:   alu_res = op_a << op_b[4:0];
      ALU_SLT:   alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU:  alu_res = {31'd0, op_a < op_b};
      ALU_XOR:   alu_res = op_a ^ op_b;
      ALU_SRL:   alu_res = op_a >> op_b[4:0];
      ALU_SRA:   alu_res = $unsigned($signed(op_a) >>> op_b[4:0]);
      ALU_OR:    alu_res = op_a | op_b;
      ALU_AND:   alu_res = op_a & op_b;
      ALU_PASSB: alu_res = op_b;
      default:   alu_res = '0;
    endcase
  end

  assign md_start = md_op & ~flush;

  md_unit #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_md (
    .Clock  (Clock),
    .nReset (nReset),
    .start  (md_start),
    .func3  (DEC_in.func3),
    .a      (fwd_rs1),
    .b      (fwd_rs2),
    .flush  (flush),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

  assign stall = md_busy;

  // rd/PC/func3 are captured in the accepting cycle, the only unstalled-predecessor cycle of a run
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      stall_q <= 1'b0;
      md_pc_q <= '0;
      md_rd_q <= '0;
      md_f3_q <= '0;
    end else begin
      stall_q <= stall;
      if (md_start && !stall_q) begin
        md_pc_q <= DEC_in.PC;
        md_rd_q <= DEC_in.rd;
        md_f3_q <= DEC_in.func3;
      end
    end
  end

  always_comb begin
    ex_n = '0;
    if (flush || stall) begin
      ex_n = '0;
    end else if (md_done) begin
      ex_n.PC     = md_pc_q;
      ex_n.rd     = md_rd_q;
      ex_n.result = md_result;
      ex_n.Wreg   = 1'b1;
      ex_n.func3  = md_f3_q;
    end else begin
      ex_n.PC         = DEC_in.PC;
      ex_n.rd         = DEC_in.rd;
      ex_n.result     = alu_res;
      ex_n.store_data = fwd_rs2;
      ex_n.Wmem       = DEC_in.Wmem;
      ex_n.Rmem       = DEC_in.Rmem;
      ex_n.Wreg       = DEC_in.Wreg;
      ex_n.func3      = DEC_in.func3;
    end
  end

  always_ff @(posedge Clock) begin
    if (!nReset) EX_out <= '0;
    else         EX_out <= ex_n;
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: forwarding, ALU ops, mul/div results, stall
// length, bubbles, flush and reset during a mul/div run.
module tb_ex_stage;
  import core_types_pkg::*;

  logic        Clock = 1'b0;
  logic        nReset;
  DEC_out_t    DEC_in;
  logic [31:0] rs1, rs2, mem_result, wb_data;
  logic        md_op, mem_Wreg, wb_Wreg, flush;
  logic [4:0]  mem_rd, wb_rd;
  EX_out_t     EX_out;
  logic        stall;

  int errors = 0;
  int checks = 0;

  ex_stage #(.BITS_PER_CYCLE(1)) dut (
    .Clock      (Clock),
    .nReset     (nReset),
    .DEC_in     (DEC_in),
    .rs1        (rs1),
    .rs2        (rs2),
    .md_op      (md_op),
    .mem_rd     (mem_rd),
    .mem_Wreg   (mem_Wreg),
    .mem_result (mem_result),
    .wb_rd      (wb_rd),
    .wb_Wreg    (wb_Wreg),
    .wb_data    (wb_data),
    .flush      (flush),
    .EX_out     (EX_out),
    .stall      (stall)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    DEC_in = '0; rs1 = '0; rs2 = '0; md_op = 1'b0; flush = 1'b0;
    mem_rd = '0; mem_Wreg = 1'b0; mem_result = '0;
    wb_rd = '0; wb_Wreg = 1'b0; wb_data = '0;
  endtask

  task automatic alu_vec(input string tag, input logic [3:0] code, input logic [31:0] a,
                         input logic [31:0] imm, input logic [31:0] exp);
    @(negedge Clock);
    clear_inputs();
    DEC_in.addr1 = 5'd1; DEC_in.addr2 = 5'd2; DEC_in.rd = 5'd3;
    DEC_in.aluCode = code; DEC_in.aluPC_m = 1'b1; DEC_in.aluImm_m = 1'b1;
    DEC_in.imm = imm; DEC_in.Wreg = 1'b1;
    rs1 = a;
    @(posedge Clock); #1;
    check(tag, EX_out.result, exp);
  endtask

  task automatic run_md(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int  scycles;
    int  bub;
    bit  fin;
    scycles = 0; bub = 0; fin = 1'b0;
    @(negedge Clock);
    clear_inputs();
    DEC_in.PC = 32'h200; DEC_in.addr1 = 5'd1; DEC_in.addr2 = 5'd2; DEC_in.rd = 5'd10;
    DEC_in.func3 = f3; DEC_in.Wreg = 1'b1;
    rs1 = a; rs2 = b; md_op = 1'b1;
    for (int i = 0; i < 200 && !fin; i++) begin
      #4;
      if (stall) begin
        scycles++;
        if (scycles > 1 && EX_out != '0) bub++;
      end else begin
        fin = 1'b1;
      end
      @(posedge Clock); #1;
      if (!fin) @(negedge Clock);
    end
    check({tag, "_done"}, 32'(fin), 32'd1);
    check({tag, "_result"}, EX_out.result, exp);
    check({tag, "_wreg"}, 32'(EX_out.Wreg), 32'd1);
    check({tag, "_rd"}, 32'(EX_out.rd), 32'd10);
    check({tag, "_stall_cycles"}, 32'(scycles), 32'd33);
    check({tag, "_bubble"}, 32'(bub), 32'd0);
    md_op = 1'b0;
    DEC_in = '0;
  endtask

  task automatic watch_quiet(input string tag, input int cycles);
    int wr;
    int st;
    wr = 0; st = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge Clock); #4;
      if (stall) st++;
      if (EX_out.Wreg) wr++;
    end
    check({tag, "_no_stall"}, 32'(st), 32'd0);
    check({tag, "_no_wreg"}, 32'(wr), 32'd0);
  endtask

  initial begin
    clear_inputs();
    nReset = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    check("rst_ex_out_zero", 32'(|EX_out), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    @(negedge Clock);
    nReset = 1'b1;

    // forwarding priority
    @(negedge Clock);
    clear_inputs();
    DEC_in.addr1 = 5'd5; DEC_in.addr2 = 5'd5; DEC_in.imm = 32'd3; DEC_in.rd = 5'd7;
    DEC_in.aluImm_m = 1'b1; DEC_in.aluPC_m = 1'b1; DEC_in.Wreg = 1'b1;
    rs1 = 32'h100; rs2 = 32'h55;
    mem_rd = 5'd5; mem_result = 32'h10; mem_Wreg = 1'b1;
    wb_rd = 5'd5; wb_data = 32'h20; wb_Wreg = 1'b1;
    @(posedge Clock); #1;
    check("fwd_mem", EX_out.result, 32'h13);
    check("fwd_mem_store", EX_out.store_data, 32'h10);
    @(negedge Clock); mem_Wreg = 1'b0;
    @(posedge Clock); #1;
    check("fwd_wb", EX_out.result, 32'h23);
    check("fwd_wb_store", EX_out.store_data, 32'h20);
    @(negedge Clock); wb_Wreg = 1'b0;
    @(posedge Clock); #1;
    check("fwd_rf", EX_out.result, 32'h103);
    check("fwd_rf_store", EX_out.store_data, 32'h55);

    // x0 never forwards
    @(negedge Clock);
    DEC_in.addr1 = 5'd0; rs1 = 32'd0;
    mem_rd = 5'd0; mem_Wreg = 1'b1; mem_result = 32'hDEAD;
    @(posedge Clock); #1;
    check("x0_no_fwd", EX_out.result, 32'h3);

    // operand selection: PC as A, rs2 as B
    @(negedge Clock);
    clear_inputs();
    DEC_in.PC = 32'h1000; DEC_in.imm = 32'd4; DEC_in.aluImm_m = 1'b1; DEC_in.aluPC_m = 1'b0;
    DEC_in.Wmem = 1'b1; DEC_in.func3 = 3'd2;
    @(posedge Clock); #1;
    check("pc_plus_imm", EX_out.result, 32'h1004);
    check("pc_field", EX_out.PC, 32'h1000);
    check("wmem_field", 32'(EX_out.Wmem), 32'd1);
    @(negedge Clock);
    clear_inputs();
    DEC_in.addr1 = 5'd1; DEC_in.addr2 = 5'd2; DEC_in.aluPC_m = 1'b1;
    rs1 = 32'h10; rs2 = 32'h20;
    @(posedge Clock); #1;
    check("rs1_plus_rs2", EX_out.result, 32'h30);

    alu_vec("add_wrap", 4'd0,  32'hFFFF_FFFF, 32'd2,         32'd1);
    alu_vec("sub",      4'd1,  32'd5,         32'd7,         32'hFFFF_FFFE);
    alu_vec("sll_b40",  4'd2,  32'd1,         32'h21,        32'd2);
    alu_vec("slt",      4'd3,  32'hFFFF_FFFF, 32'd1,         32'd1);
    alu_vec("sltu",     4'd4,  32'hFFFF_FFFF, 32'd1,         32'd0);
    alu_vec("xor",      4'd5,  32'hF0F0,      32'hFF00,      32'h0FF0);
    alu_vec("srl",      4'd6,  32'h8000_0000, 32'd4,         32'h0800_0000);
    alu_vec("sra",      4'd7,  32'h8000_0000, 32'd4,         32'hF800_0000);
    alu_vec("or",       4'd8,  32'hF0,        32'h0F,        32'hFF);
    alu_vec("and",      4'd9,  32'hF0,        32'h3C,        32'h30);
    alu_vec("passb",    4'd10, 32'hAAAA,      32'h1234,      32'h1234);
    alu_vec("code13",   4'd13, 32'hAAAA,      32'h1234,      32'd0);

    run_md("div_neg",    3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    run_md("rem_neg",    3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    run_md("divu_zero",  3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF);
    run_md("remu_zero",  3'd7, 32'd5,         32'd0,         32'd5);
    run_md("div_ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_md("rem_ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_md("mulh",       3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_md("mulhsu",     3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_md("mulhu",      3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_md("mul",        3'd0, 32'd7,         32'd6,         32'd42);
    run_md("divu",       3'd5, 32'd100,       32'd7,         32'd14);
    run_md("remu",       3'd7, 32'd100,       32'd7,         32'd2);

    // flush in the 10th BUSY cycle
    @(negedge Clock);
    clear_inputs();
    DEC_in.addr1 = 5'd1; DEC_in.addr2 = 5'd2; DEC_in.rd = 5'd10; DEC_in.func3 = 3'd4;
    rs1 = 32'd100; rs2 = 32'd7; md_op = 1'b1;
    repeat (10) @(negedge Clock);
    flush = 1'b1; md_op = 1'b0; DEC_in = '0;
    @(negedge Clock);
    flush = 1'b0;
    #4;
    check("flush_stall_next", 32'(stall), 32'd0);
    check("flush_bubble", 32'(|EX_out), 32'd0);
    watch_quiet("flush", 40);
    alu_vec("add_after_flush", 4'd0, 32'd40, 32'd2, 32'd42);

    // reset in the middle of BUSY
    @(negedge Clock);
    clear_inputs();
    DEC_in.addr1 = 5'd1; DEC_in.addr2 = 5'd2; DEC_in.rd = 5'd10; DEC_in.func3 = 3'd0;
    rs1 = 32'd7; rs2 = 32'd6; md_op = 1'b1;
    repeat (6) @(negedge Clock);
    nReset = 1'b0; md_op = 1'b0; DEC_in = '0;
    @(posedge Clock); #1;
    check("rst_busy_ex_zero", 32'(|EX_out), 32'd0);
    @(negedge Clock);
    nReset = 1'b1;
    #4;
    check("rst_busy_stall", 32'(stall), 32'd0);
    watch_quiet("rst_busy", 40);
    run_md("mul_after_rst", 3'd0, 32'd7, 32'd6, 32'd42);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
